// File: rtl/auto_player.sv
// Automatic player: watches the lit-LED pattern, waits a programmable
// number of timebase ticks, then toggles the matching switch bit once per
// lit pattern. A round is abandoned if the target LED goes dark first.
module auto_player #(
  parameter int DELAY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               tick,
  input  logic [7:0]         LED,
  input  logic [DELAY_W-1:0] delay,
  output logic [7:0]         switch,
  output logic               flip,
  output logic               missed,
  output logic               busy,
  output logic [7:0]         flip_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t             state;
  logic [DELAY_W-1:0] cnt;
  logic [7:0]         target;
  logic [7:0]         served;

  // Isolate the lowest set bit: v & -v leaves only the least significant one.
  function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  // busy is a pure decode of the state register, so it stays glitch-free.
  assign busy = (state != IDLE);

  // Round sequencing: arm on a lit pattern, count ticks, flip once, then
  // hold until the pattern changes. Priority: rst, en=0, abort, countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      target   <= '0;
      served   <= '0;
      switch   <= '0;
      flip     <= 1'b0;
      missed   <= 1'b0;
      flip_cnt <= '0;
    end else begin
      flip   <= 1'b0;
      missed <= 1'b0;
      if (!en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (LED != 8'd0) begin
              target <= lowest_onehot(LED);
              cnt    <= delay;
              state  <= WAIT;
            end
          end
          WAIT: begin
            if ((LED & target) == 8'd0) begin
              // Target went dark before we reacted: give up this round.
              missed <= 1'b1;
              state  <= IDLE;
            end else if (cnt == '0) begin
              // Countdown finished; tick is irrelevant for the flip itself.
              switch   <= switch ^ target;
              flip     <= 1'b1;
              flip_cnt <= flip_cnt + 8'd1;
              served   <= LED;
              state    <= HOLD;
            end else if (tick) begin
              cnt <= cnt - DELAY_W'(1);
            end
          end
          HOLD: begin
            // Any change, including going dark, ends the served pattern.
            if (LED != served) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_auto_player.sv
// Self-checking bench for auto_player: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural round model.
module tb_auto_player;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] led = 8'd0;
  logic [7:0] delay = 8'd0;
  logic [7:0] sw;
  logic       flip;
  logic       missed;
  logic       busy;
  logic [7:0] flip_cnt;

  int vectors = 0;
  int miscompares = 0;

  auto_player #(.DELAY_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .LED(led), .delay(delay),
    .switch(sw), .flip(flip), .missed(missed), .busy(busy), .flip_cnt(flip_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: a round is "counting" toward a target LED index with
  // some ticks remaining, or "holding" a served pattern, or neither.
  bit         m_counting = 0;
  bit         m_holding = 0;
  int         m_ticks_left = 0;
  int         m_tgt = 0;
  logic [7:0] m_served = 0;
  logic [7:0] m_switch = 0;
  logic [7:0] m_flips = 0;
  bit         m_flip = 0;
  bit         m_missed = 0;

  task automatic model_edge();
    m_flip = 0;
    m_missed = 0;
    if (rst) begin
      m_counting = 0; m_holding = 0; m_ticks_left = 0; m_tgt = 0;
      m_served = 0; m_switch = 0; m_flips = 0;
    end else if (!en) begin
      m_counting = 0; m_holding = 0;
    end else if (m_counting) begin
      if (!led[m_tgt]) begin
        m_missed = 1; m_counting = 0;
      end else if (m_ticks_left == 0) begin
        m_switch[m_tgt] = ~m_switch[m_tgt];
        m_flip = 1;
        m_flips = m_flips + 8'd1;
        m_served = led;
        m_counting = 0; m_holding = 1;
      end else if (tick) begin
        m_ticks_left = m_ticks_left - 1;
      end
    end else if (m_holding) begin
      if (led != m_served) m_holding = 0;
    end else if (led != 0) begin
      for (int i = 7; i >= 0; i--) if (led[i]) m_tgt = i;
      m_ticks_left = int'(delay);
      m_counting = 1;
    end
  endtask

  // One clock edge: inputs are stable at the edge, outputs settle 1ns later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; led = 0; tick = 0; delay = 0;
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; led = 8'h01; tick = 1; delay = 0;
    cycle(); cycle();
    vectors++;
    if ({sw, flip, missed, busy, flip_cnt} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_state: got sw=%h flip=%b missed=%b busy=%b cnt=%0d want all 0", sw, flip, missed, busy, flip_cnt);
    end
    rst = 0;
    cycle();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL arm_after_reset: got busy=%b want 1", busy);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    en = 1; tick = 1; delay = 3; led = 8'b0000_0100;
    cycle();
    for (int i = 1; i <= 3; i++) begin
      cycle();
      vectors++;
      if (flip !== 1'b0 || sw !== 8'd0) begin
        miscompares++;
        $display("FAIL basic_early_%0d: got flip=%b sw=%h want 0 00", i, flip, sw);
      end
    end
    cycle();
    vectors++;
    if (sw !== 8'b0000_0100 || flip !== 1'b1 || flip_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL basic_flip: got sw=%h flip=%b cnt=%0d want 04 1 1", sw, flip, flip_cnt);
    end
    cycle();
    vectors++;
    if (flip !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_hold: got flip=%b busy=%b want 0 1", flip, busy);
    end
    led = 8'd0;
    cycle();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_release: got busy=%b want 0", busy);
    end
  endtask

  // Run one round on pattern p with delay d (tick high), release with LED=0.
  task automatic round(input logic [7:0] p, input logic [7:0] d);
    en = 1; tick = 1; delay = d; led = p;
    for (int i = 0; i <= int'(d) + 1; i++) cycle();
    led = 8'd0;
    cycle();
  endtask

  task automatic test_multibit();
    do_reset();
    round(8'b1000_0000, 8'd1);
    vectors++;
    if (sw !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL multibit_pre: got sw=%h want 80", sw);
    end
    en = 1; tick = 1; delay = 2; led = 8'b1001_0000;
    for (int i = 0; i < 3; i++) cycle();
    vectors++;
    if (sw !== 8'b1000_0000 || flip !== 1'b0) begin
      miscompares++;
      $display("FAIL multibit_before: got sw=%h flip=%b want 80 0", sw, flip);
    end
    cycle();
    vectors++;
    if (sw !== 8'b1001_0000 || flip !== 1'b1) begin
      miscompares++;
      $display("FAIL multibit_after: got sw=%h flip=%b want 90 1", sw, flip);
    end
    led = 8'd0;
    cycle();
    round(8'b0001_0000, 8'd2);
    vectors++;
    if (sw !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL retarget: got sw=%h want 80", sw);
    end
  endtask

  task automatic test_abort();
    do_reset();
    en = 1; tick = 1; delay = 10; led = 8'b0000_0001;
    cycle();
    for (int i = 0; i < 4; i++) cycle();
    led = 8'd0;
    cycle();
    vectors++;
    if (missed !== 1'b1 || sw !== 8'd0 || busy !== 1'b0 || flip !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: got missed=%b sw=%h busy=%b flip=%b want 1 00 0 0", missed, sw, busy, flip);
    end
    cycle();
    vectors++;
    if (missed !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_width: got missed=%b want 0", missed);
    end
  endtask

  task automatic test_sparse_tick();
    int first_flip;
    do_reset();
    first_flip = -1;
    en = 1; tick = 0; delay = 2; led = 8'b0100_0000;
    cycle();
    for (int i = 1; i <= 40; i++) begin
      tick = (i % 4 == 0);
      cycle();
      if (flip === 1'b1 && first_flip < 0) first_flip = i;
    end
    tick = 0;
    vectors++;
    if (first_flip != 9) begin
      miscompares++;
      $display("FAIL sparse_tick: got first flip at edge %0d want 9", first_flip);
    end
  endtask

  task automatic test_hold_relight();
    int n;
    do_reset();
    en = 1; tick = 1; delay = 1; led = 8'b0010_0000;
    n = 0;
    for (int i = 0; i < 50; i++) begin cycle(); n += (flip === 1'b1); end
    vectors++;
    if (n != 1 || sw !== 8'b0010_0000) begin
      miscompares++;
      $display("FAIL hold_once: got flips=%0d sw=%h want 1 20", n, sw);
    end
    led = 8'd0;
    cycle();
    led = 8'b0010_0000;
    n = 0;
    for (int i = 0; i < 50; i++) begin cycle(); n += (flip === 1'b1); end
    vectors++;
    if (n != 1 || sw !== 8'd0 || flip_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL relight: got flips=%0d sw=%h cnt=%0d want 1 00 2", n, sw, flip_cnt);
    end
    led = 8'd0;
    cycle();
  endtask

  task automatic test_reset_enable();
    do_reset();
    en = 1; tick = 1; delay = 10; led = 8'b0000_0010;
    for (int i = 0; i < 4; i++) cycle();
    rst = 1;
    cycle();
    vectors++;
    if ({sw, flip, missed, busy, flip_cnt} !== 19'd0) begin
      miscompares++;
      $display("FAIL rst_mid_wait: got sw=%h flip=%b missed=%b busy=%b cnt=%0d want all 0", sw, flip, missed, busy, flip_cnt);
    end
    rst = 0; delay = 0;
    cycle(); cycle();
    led = 8'd0;
    cycle();
    vectors++;
    if (sw !== 8'b0000_0010 || flip_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL post_rst_round: got sw=%h cnt=%0d want 02 1", sw, flip_cnt);
    end
    delay = 10; led = 8'b0000_1000;
    for (int i = 0; i < 3; i++) cycle();
    en = 0;
    cycle();
    vectors++;
    if (busy !== 1'b0 || sw !== 8'b0000_0010 || flip !== 1'b0 || missed !== 1'b0 || flip_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL en_low: got busy=%b sw=%h flip=%b missed=%b cnt=%0d want 0 02 0 0 1", busy, sw, flip, missed, flip_cnt);
    end
    led = 8'd0;
    cycle();
    vectors++;
    if (missed !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL en_low_dark: got missed=%b busy=%b want 0 0", missed, busy);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1; tick = 1; delay = 0;
    for (int r = 0; r < 256; r++) begin
      led = 8'b0000_0001; cycle(); cycle();
      led = 8'd0; cycle();
      if (r == 254) begin
        vectors++;
        if (flip_cnt !== 8'd255) begin
          miscompares++;
          $display("FAIL wrap_255: got cnt=%0d want 255", flip_cnt);
        end
      end
    end
    vectors++;
    if (flip_cnt !== 8'd0 || sw !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap_0: got cnt=%0d sw=%h want 0 00", flip_cnt, sw);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 31) != 0);
      tick = $urandom_range(0, 1);
      delay = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: led = 8'd0;
          1: led = 8'(1 << $urandom_range(0, 7));
          default: led = 8'($urandom);
        endcase
      end
      cycle();
      vectors++;
      if (sw !== m_switch || flip !== m_flip || missed !== m_missed ||
          busy !== (m_counting || m_holding) || flip_cnt !== m_flips) begin
        miscompares++;
        $display("FAIL random_%0d: got sw=%h f=%b m=%b b=%b c=%0d want sw=%h f=%b m=%b b=%b c=%0d",
                 i, sw, flip, missed, busy, flip_cnt, m_switch, m_flip, m_missed,
                 (m_counting || m_holding), m_flips);
      end
      if (flip === 1'b1 && missed === 1'b1) begin
        miscompares++;
        $display("FAIL random_pulse_overlap_%0d: got flip=1 missed=1 want not both", i);
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multibit();
    test_abort();
    test_sparse_tick();
    test_hold_relight();
    test_reset_enable();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
